// File: rtl/text_cell_renderer.sv
// Character-cell text renderer: takes ASCII codes over valid/ready, fetches glyph rows
// from an external 1-cycle ROM and plots one pixel per cycle into a VGA frame adapter.
module text_cell_renderer #(
  parameter int GLYPH_W          = 8,
  parameter int GLYPH_H          = 16,
  parameter int COLS             = 40,
  parameter int ROWS             = 15,
  parameter int COLOUR_W         = 3,
  parameter int CLEAR_ON_NEWLINE = 1,
  localparam int XW  = $clog2(COLS * GLYPH_W),
  localparam int YW  = $clog2(ROWS * GLYPH_H),
  localparam int CW  = $clog2(COLS),
  localparam int RW  = $clog2(ROWS),
  localparam int PXW = $clog2(GLYPH_W),
  localparam int PYW = $clog2(GLYPH_H)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           char_in,
  input  logic                 char_valid,
  output logic                 char_ready,
  input  logic [COLOUR_W-1:0]  fg_colour,
  input  logic [COLOUR_W-1:0]  bg_colour,
  output logic [7+PYW-1:0]     rom_addr,
  input  logic [GLYPH_W-1:0]   rom_data,
  output logic [XW-1:0]        x_out,
  output logic [YW-1:0]        y_out,
  output logic [COLOUR_W-1:0]  colour_out,
  output logic                 plot,
  output logic [CW-1:0]        cursor_col,
  output logic [RW-1:0]        cursor_row
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLOT,
    S_ADVANCE,
    S_CLEAR
  } state_e;

  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [PXW-1:0] PX_LAST  = PXW'(GLYPH_W - 1);
  localparam logic [PYW-1:0] PY_LAST  = PYW'(GLYPH_H - 1);
  localparam logic [XW-1:0]  X_LAST   = XW'(COLS * GLYPH_W - 1);
  localparam logic [XW-1:0]  GW_X     = XW'(GLYPH_W);
  localparam logic [YW-1:0]  GH_Y     = YW'(GLYPH_H);

  state_e              state_q;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [6:0]          char_q;
  logic [COLOUR_W-1:0] fg_q;
  logic [COLOUR_W-1:0] bg_q;
  logic [PXW-1:0]      px_q;
  logic [PYW-1:0]      py_q;
  logic                is_bs_q;
  logic                plot_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [7+PYW-1:0]    rom_addr_q;

  logic [RW-1:0]       row_inc_d;
  logic [CW-1:0]       bs_col_d;
  logic [RW-1:0]       bs_row_d;
  logic [XW-1:0]       x_base_d;
  logic [YW-1:0]       y_base_d;
  logic [YW-1:0]       y_next_row_d;
  logic [PXW-1:0]      pix_idx_d;
  logic [COLOUR_W-1:0] pix_colour_d;
  logic                printable_d;

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    row_inc_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    bs_col_d     = col_q;
    bs_row_d     = row_q;
    if (col_q != '0) begin
      bs_col_d = col_q - 1'b1;
    end else if (row_q != '0) begin
      bs_col_d = COL_LAST;
      bs_row_d = row_q - 1'b1;
    end
    x_base_d     = XW'(col_q) * GW_X;
    y_base_d     = YW'(row_q) * GH_Y;
    y_next_row_d = YW'(row_inc_d) * GH_Y;
    pix_idx_d    = PX_LAST - px_q;
    pix_colour_d = rom_data[pix_idx_d] ? fg_q : bg_q;
    printable_d  = (char_in >= 7'h20) && (char_in <= 7'h7E);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      char_q     <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      is_bs_q    <= 1'b0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      rom_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (char_valid) begin
            fg_q <= fg_colour;
            bg_q <= bg_colour;
            px_q <= '0;
            py_q <= '0;
            if (printable_d) begin
              char_q     <= char_in;
              is_bs_q    <= 1'b0;
              rom_addr_q <= {char_in, {PYW{1'b0}}};
              state_q    <= S_FETCH;
            end else if (char_in == 7'h08) begin
              // Backspace erases by drawing a space in the cell it steps back into.
              char_q     <= 7'h20;
              is_bs_q    <= 1'b1;
              col_q      <= bs_col_d;
              row_q      <= bs_row_d;
              rom_addr_q <= {7'h20, {PYW{1'b0}}};
              state_q    <= S_FETCH;
            end else if (char_in == 7'h0D) begin
              col_q <= '0;
              row_q <= row_inc_d;
              if (CLEAR_ON_NEWLINE != 0) begin
                plot_q   <= 1'b1;
                x_q      <= '0;
                y_q      <= y_next_row_d;
                colour_q <= bg_colour;
                state_q  <= S_CLEAR;
              end
            end
          end
        end

        S_FETCH: begin
          plot_q  <= 1'b1;
          px_q    <= '0;
          x_q     <= x_base_d;
          y_q     <= y_base_d + YW'(py_q);
          state_q <= S_PLOT;
        end

        S_PLOT: begin
          colour_q <= pix_colour_d;
          if (px_q == PX_LAST) begin
            plot_q <= 1'b0;
            if (py_q == PY_LAST) begin
              state_q <= is_bs_q ? S_IDLE : S_ADVANCE;
            end else begin
              py_q       <= py_q + 1'b1;
              rom_addr_q <= {char_q, py_q + 1'b1};
              state_q    <= S_FETCH;
            end
          end else begin
            px_q <= px_q + 1'b1;
            x_q  <= x_q + 1'b1;
          end
        end

        S_ADVANCE: begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= row_inc_d;
            if (CLEAR_ON_NEWLINE != 0) begin
              plot_q   <= 1'b1;
              x_q      <= '0;
              y_q      <= y_next_row_d;
              py_q     <= '0;
              colour_q <= bg_q;
              state_q  <= S_CLEAR;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            col_q   <= col_q + 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_CLEAR: begin
          // x sweeps the full row width fastest; the final pixel leaves x/y where they are.
          if (x_q == X_LAST) begin
            if (py_q == PY_LAST) begin
              plot_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              x_q  <= '0;
              py_q <= py_q + 1'b1;
              y_q  <= y_q + 1'b1;
            end
          end else begin
            x_q <= x_q + 1'b1;
          end
        end

        default: begin
          plot_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel colour comes straight from ROM data during PLOT because the ROM row lands that cycle.
  assign colour_out = (state_q == S_PLOT) ? pix_colour_d : colour_q;
  assign char_ready = reset_n && (state_q == S_IDLE);
  assign plot       = plot_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign rom_addr   = rom_addr_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_cell_renderer.sv
// Directed bench for text_cell_renderer on a 4x2 cell grid of 8x16 glyphs with a behavioural
// 1-cycle glyph ROM; every plotted pixel is compared against a bench-built expected stream.
module tb_text_cell_renderer;

  localparam int XW = 5;
  localparam int YW = 5;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    c;
  } pix_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [6:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic [2:0]    fg_colour;
  logic [2:0]    bg_colour;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_data = '0;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [2:0]    colour_out;
  logic          plot;
  logic [1:0]    cursor_col;
  logic [0:0]    cursor_row;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int t_send = 0;
  int first_plot_cyc = -1;
  pix_t plots[$];
  pix_t exp_q[$];

  text_cell_renderer #(
    .GLYPH_W(8), .GLYPH_H(16), .COLS(4), .ROWS(2), .COLOUR_W(3), .CLEAR_ON_NEWLINE(1)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .fg_colour  (fg_colour),
    .bg_colour  (bg_colour),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [6:0] ch, input logic [3:0] r);
    if (ch == 7'h20) return 8'h00;
    if (ch == 7'h41) return 8'hF0;
    return {ch[3:0], r} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom_fn(rom_addr[10:4], rom_addr[3:0]);
  end

  always @(negedge clk) begin
    if (plot) begin
      if (plots.size() == 0) first_plot_cyc = cyc;
      plots.push_back('{x_out, y_out, colour_out});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_char(input int col, input int row, input logic [6:0] ch,
                           input logic [2:0] fg, input logic [2:0] bg);
    logic [7:0] bits;
    for (int py = 0; py < 16; py++) begin
      bits = rom_fn(ch, 4'(py));
      for (int px = 0; px < 8; px++)
        exp_q.push_back('{XW'(col * 8 + px), YW'(row * 16 + py), bits[7-px] ? fg : bg});
    end
  endtask

  task automatic push_clear(input int row, input logic [2:0] bg);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++)
        exp_q.push_back('{XW'(x), YW'(row * 16 + y), bg});
  endtask

  // Caller is at a negedge with char_ready high; returns at the negedge after the transfer.
  task automatic send(input logic [6:0] ch, input logic [2:0] fg, input logic [2:0] bg);
    plots.delete();
    first_plot_cyc = -1;
    char_in    = ch;
    fg_colour  = fg;
    bg_colour  = bg;
    char_valid = 1'b1;
    t_send     = cyc;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int ready_cyc);
    int n = 0;
    while (!char_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ready_cyc = cyc;
    check({tag, "_ready"}, char_ready, 1);
  endtask

  task automatic compare_plots(input string tag);
    int mism = 0;
    int n = (plots.size() < exp_q.size()) ? plots.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (plots[i] !== exp_q[i]) mism++;
    check({tag, "_count"}, plots.size(), exp_q.size());
    check({tag, "_pixels"}, mism, 0);
    exp_q.delete();
  endtask

  task automatic run_op(input string tag, input logic [6:0] ch, input logic [2:0] fg,
                        input logic [2:0] bg, input int ecol, input int erow);
    int rc;
    send(ch, fg, bg);
    wait_ready(tag, rc);
    compare_plots(tag);
    check({tag, "_col"}, cursor_col, ecol);
    check({tag, "_row"}, cursor_row, erow);
  endtask

  initial begin
    int rc;
    bit found;
    reset_n    = 1'b0;
    char_valid = 1'b0;
    char_in    = '0;
    fg_colour  = '0;
    bg_colour  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", char_ready, 0);
    check("rst_plot", plot, 0);
    check("rst_xy", {x_out, y_out}, 0);
    check("rst_colour", colour_out, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_cursor", {cursor_col, cursor_row}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", char_ready, 1);

    // 'A' at (0,0): left half fg, right half bg, timing of first plot and return to idle.
    push_char(0, 0, 7'h41, 3'b010, 3'b000);
    send(7'h41, 3'b010, 3'b000);
    check("a_busy", char_ready, 0);
    wait_ready("a", rc);
    check("a_first_plot_cyc", first_plot_cyc, t_send + 2);
    check("a_idle_cyc", rc, t_send + 146);
    compare_plots("a");
    check("a_cursor", {cursor_col, cursor_row}, {2'd1, 1'b0});
    check("a_hold_x", x_out, 7);
    check("a_hold_y", y_out, 15);
    check("a_hold_colour", colour_out, 0);

    // Fill row 0; the last column wraps to row 1, which is cleared in bg.
    push_char(1, 0, 7'h42, 3'b001, 3'b000);
    run_op("b", 7'h42, 3'b001, 3'b000, 2, 0);
    push_char(2, 0, 7'h43, 3'b100, 3'b000);
    run_op("c", 7'h43, 3'b100, 3'b000, 3, 0);
    push_char(3, 0, 7'h44, 3'b110, 3'b101);
    push_clear(1, 3'b101);
    run_op("d_wrap", 7'h44, 3'b110, 3'b101, 0, 1);

    // CR on the last row wraps to row 0 and clears it.
    push_clear(0, 3'b011);
    run_op("cr_wrap", 7'h0D, 3'b000, 3'b011, 0, 0);

    // Backspace: mid-row, to column 0, at (0,0), and across a row boundary.
    push_char(0, 0, 7'h45, 3'b001, 3'b000);
    run_op("e", 7'h45, 3'b001, 3'b000, 1, 0);
    push_char(1, 0, 7'h46, 3'b001, 3'b000);
    run_op("f", 7'h46, 3'b001, 3'b000, 2, 0);
    push_char(1, 0, 7'h20, 3'b111, 3'b001);
    run_op("bs_mid", 7'h08, 3'b111, 3'b001, 1, 0);
    push_char(0, 0, 7'h20, 3'b111, 3'b001);
    run_op("bs_col0", 7'h08, 3'b111, 3'b001, 0, 0);
    push_char(0, 0, 7'h20, 3'b111, 3'b110);
    run_op("bs_origin", 7'h08, 3'b111, 3'b110, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push_char(i, 0, 7'(7'h47 + i), 3'b011, 3'b000);
      if (i == 3) push_clear(1, 3'b000);
      run_op("fill", 7'(7'h47 + i), 3'b011, 3'b000, (i + 1) % 4, (i == 3) ? 1 : 0);
    end
    push_char(3, 0, 7'h20, 3'b111, 3'b010);
    run_op("bs_prev_row", 7'h08, 3'b111, 3'b010, 3, 0);

    // Non-printable codes are consumed without plotting.
    send(7'h07, 3'b111, 3'b111);
    check("bel_ready", char_ready, 1);
    repeat (4) @(negedge clk);
    check("bel_plots", plots.size(), 0);
    check("bel_cursor", {cursor_col, cursor_row}, {2'd3, 1'b0});
    send(7'h7F, 3'b111, 3'b111);
    check("del_ready", char_ready, 1);
    repeat (4) @(negedge clk);
    check("del_plots", plots.size(), 0);
    check("del_cursor", {cursor_col, cursor_row}, {2'd3, 1'b0});

    // Reset in the middle of a glyph aborts plotting at once.
    send(7'h4B, 3'b101, 3'b000);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (plot && x_out == 5'd27 && y_out == 5'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("midrst_reached", found, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_plot", plot, 0);
    check("midrst_cursor", {cursor_col, cursor_row}, 0);
    check("midrst_x", x_out, 0);
    check("midrst_ready_low", char_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", char_ready, 1);
    check("midrst_idle_plot", plot, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
